// File: rtl/fifteen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifteen_pkg
// Description : Shared motion encodings, player states and blank-move helpers
//               for the 15-puzzle motion interface.
// Revision    : 1.0 - initial release
// ============================================================================
package fifteen_pkg;

    localparam logic [1:0] MOTION_UP    = 2'b00;
    localparam logic [1:0] MOTION_RIGHT = 2'b01;
    localparam logic [1:0] MOTION_DOWN  = 2'b10;
    localparam logic [1:0] MOTION_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // A move is legal when the blank stays on the 4x4 grid after moving.
    function automatic logic move_legal(input logic [3:0] pos, input logic [1:0] m);
        logic ok;
        ok = 1'b0;
        case (m)
            MOTION_UP:    ok = (pos < 4'd12);
            MOTION_RIGHT: ok = (pos[1:0] != 2'd0);
            MOTION_DOWN:  ok = (pos >= 4'd4);
            default:      ok = (pos[1:0] != 2'd3);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] next_zero(input logic [3:0] pos, input logic [1:0] m);
        logic [3:0] nxt;
        nxt = pos;
        case (m)
            MOTION_UP:    nxt = pos + 4'd4;
            MOTION_RIGHT: nxt = pos - 4'd1;
            MOTION_DOWN:  nxt = pos - 4'd4;
            default:      nxt = pos + 4'd1;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifteen_move_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifteen_move_fifo
// Description : Circular DEPTH x 2-bit move buffer with push, pop and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifteen_move_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [1:0] i_push_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [1:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    r_mem_q [DEPTH];
    logic [1:0]    w_mem_d [DEPTH];
    logic [AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0] r_count_q,  w_count_d;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (i_push) begin
                w_mem_d[r_wr_ptr_q] = i_push_data;
                w_wr_ptr_d          = r_wr_ptr_q + AW'(1);
            end
            if (i_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + AW'(1);
            end
            if (i_push && !i_pop) begin
                w_count_d = r_count_q + CW'(1);
            end else if (i_pop && !i_push) begin
                w_count_d = r_count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_head  = r_mem_q[r_rd_ptr_q];
    assign o_full  = (r_count_q == CW'(DEPTH));
    assign o_empty = (r_count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fifteen_move_player.sv
`default_nettype none
// ============================================================================
// Module      : fifteen_move_player
// Description : Buffers a host move list and replays it one move per cycle to
//               the 15-puzzle, rejecting illegal moves and reporting solve step.
// Revision    : 1.0 - initial release
// ============================================================================
module fifteen_move_player
    import fifteen_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [1:0]    wr_motion,
    output logic          wr_ready,
    input  logic          start,
    input  logic          clear,
    input  logic [3:0]    init_zero_pos,
    input  logic          solved,
    output logic [1:0]    motion,
    output logic          motion_valid,
    output logic          busy,
    output logic          done,
    output logic          solved_flag,
    output logic          illegal,
    output logic [CW-1:0] step_count,
    output logic [3:0]    zero_pos
);

    state_t        r_state_q, w_state_d;
    logic [3:0]    r_zero_pos_q, w_zero_pos_d;
    logic [CW-1:0] r_step_count_q, w_step_count_d;
    logic          r_solved_flag_q, w_solved_flag_d;
    logic          r_illegal_q, w_illegal_d;

    logic          w_push, w_pop, w_flush;
    logic          w_full, w_empty;
    logic [1:0]    w_head;
    logic          w_wr_ready;
    logic          w_motion_valid;
    logic [1:0]    w_motion;
    logic          w_done;

    fifteen_move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (wr_motion),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // wr_ready is masked during reset so every output reads 0 while rst is high.
    assign wr_ready = w_wr_ready && !rst;
    assign w_push   = wr_valid && wr_ready;

    always_comb begin
        w_state_d       = r_state_q;
        w_zero_pos_d    = r_zero_pos_q;
        w_step_count_d  = r_step_count_q;
        w_solved_flag_d = r_solved_flag_q;
        w_illegal_d     = r_illegal_q;
        w_pop           = 1'b0;
        w_flush         = 1'b0;
        w_wr_ready      = 1'b0;
        w_motion_valid  = 1'b0;
        w_motion        = 2'b00;
        w_done          = 1'b0;

        if (clear) begin
            w_flush         = 1'b1;
            w_solved_flag_d = 1'b0;
            w_illegal_d     = 1'b0;
            w_step_count_d  = '0;
            w_state_d       = IDLE;
        end else begin
            case (r_state_q)
                IDLE: begin
                    w_wr_ready = !w_full;
                    if (start) begin
                        w_zero_pos_d    = init_zero_pos;
                        w_step_count_d  = '0;
                        w_solved_flag_d = 1'b0;
                        w_illegal_d     = 1'b0;
                        w_state_d       = PLAY;
                    end
                end
                PLAY: begin
                    if (solved) begin
                        w_solved_flag_d = 1'b1;
                        w_flush         = 1'b1;
                        w_state_d       = DONE;
                    end else if (w_empty) begin
                        w_state_d = DONE;
                    end else if (!move_legal(r_zero_pos_q, w_head)) begin
                        w_illegal_d = 1'b1;
                        w_flush     = 1'b1;
                        w_state_d   = ERR;
                    end else begin
                        w_pop          = 1'b1;
                        w_motion_valid = 1'b1;
                        w_motion       = w_head;
                        w_zero_pos_d   = next_zero(r_zero_pos_q, w_head);
                        w_step_count_d = r_step_count_q + CW'(1);
                    end
                end
                DONE: begin
                    w_done    = 1'b1;
                    w_state_d = IDLE;
                end
                ERR: begin
                    w_state_d = ERR;
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= IDLE;
            r_zero_pos_q    <= '0;
            r_step_count_q  <= '0;
            r_solved_flag_q <= 1'b0;
            r_illegal_q     <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_zero_pos_q    <= w_zero_pos_d;
            r_step_count_q  <= w_step_count_d;
            r_solved_flag_q <= w_solved_flag_d;
            r_illegal_q     <= w_illegal_d;
        end
    end

    assign motion       = w_motion;
    assign motion_valid = w_motion_valid;
    assign done         = w_done;
    assign busy         = (r_state_q == PLAY);
    assign solved_flag  = r_solved_flag_q;
    assign illegal      = r_illegal_q;
    assign step_count   = r_step_count_q;
    assign zero_pos     = r_zero_pos_q;

endmodule
`default_nettype wire

// File: tb/tb_fifteen_move_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifteen_move_player
// Description : Directed bench: move player driving a behavioural 15-puzzle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifteen_move_player;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [63:0] SOLVED_BOARD = 64'h123456789abcdef0;
    localparam logic [63:0] BOARD_Z1     = 64'h123456789abcde0f;
    localparam logic [63:0] BOARD_Z3     = 64'h123456789abc0def;
    localparam logic [63:0] BOARD_Z5     = 64'h123456789a0cdefb;
    localparam logic [1:0]  M_RIGHT      = 2'b01;
    localparam logic [1:0]  M_LEFT       = 2'b11;

    logic          clk = 1'b0;
    logic          rst, wr_valid, wr_ready, start, clear, solved;
    logic [1:0]    wr_motion, motion;
    logic [3:0]    init_zero_pos, zero_pos;
    logic          motion_valid, busy, done, solved_flag, illegal;
    logic [CW-1:0] step_count;

    logic [63:0]   board;
    logic          load_req;
    logic [63:0]   load_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifteen_move_player #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_motion     (wr_motion),
        .wr_ready      (wr_ready),
        .start         (start),
        .clear         (clear),
        .init_zero_pos (init_zero_pos),
        .solved        (solved),
        .motion        (motion),
        .motion_valid  (motion_valid),
        .busy          (busy),
        .done          (done),
        .solved_flag   (solved_flag),
        .illegal       (illegal),
        .step_count    (step_count),
        .zero_pos      (zero_pos)
    );

    // Behavioural puzzle: swaps the blank with its neighbour on each valid motion.
    function automatic int find_zero(input logic [63:0] b);
        int p;
        p = 0;
        for (int i = 0; i < 16; i++) if (b[i*4 +: 4] == 4'h0) p = i;
        return p;
    endfunction

    function automatic logic [63:0] apply_move(input logic [63:0] b, input logic [1:0] m);
        logic [63:0] r;
        int p, t;
        p = find_zero(b);
        case (m)
            2'b00:   t = p + 4;
            2'b01:   t = p - 1;
            2'b10:   t = p - 4;
            default: t = p + 1;
        endcase
        r = b;
        if (t >= 0 && t < 16) begin
            r[p*4 +: 4] = b[t*4 +: 4];
            r[t*4 +: 4] = 4'h0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (load_req)          board <= load_val;
        else if (motion_valid) board <= apply_move(board, motion);
    end
    assign solved = (board == SOLVED_BOARD);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_board(input logic [63:0] b);
        load_req = 1'b1; load_val = b; tick(); load_req = 1'b0;
    endtask

    task automatic push_move(input logic [1:0] m);
        wr_valid = 1'b1; wr_motion = m; tick(); wr_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] z);
        start = 1'b1; init_zero_pos = z; tick(); start = 1'b0;
    endtask

    // Cycle k=0 is the cycle right after the accepted start.
    task automatic run_play(input int max_cyc, output int moves, output int first_mv,
                            output int last_mv, output int done_at, output int bad_motion);
        moves = 0; first_mv = -1; last_mv = -1; done_at = -1; bad_motion = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (motion_valid) begin
                moves++;
                if (first_mv < 0) first_mv = k;
                last_mv = k;
            end else if (motion !== 2'b00) begin
                bad_motion++;
            end
            if (done) done_at = k;
            tick();
            if (done_at >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        @(negedge clk);
        checks++; if ({wr_ready, motion_valid, motion, busy, done, solved_flag, illegal} !== 8'h00) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000000", {wr_ready, motion_valid, motion, busy, done, solved_flag, illegal}); end
        checks++; if ({step_count, zero_pos} !== '0) begin
            failures++; $display("FAIL reset_counts got step=%0d zpos=%0d exp 0 0", step_count, zero_pos); end
        tick(); rst = 1'b0;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        tick();
    endtask

    task automatic test_single_solve();
        int mv, fm, lm, da, bm;
        set_board(BOARD_Z1);
        push_move(M_RIGHT);
        pulse_start(4'd1);
        run_play(10, mv, fm, lm, da, bm);
        checks++; if (mv !== 1) begin failures++; $display("FAIL t1_moves got=%0d exp=1", mv); end
        checks++; if (fm !== 0) begin failures++; $display("FAIL t1_first_move got=%0d exp=0", fm); end
        checks++; if (da !== 2) begin failures++; $display("FAIL t1_done_cycle got=%0d exp=2", da); end
        checks++; if (bm !== 0) begin failures++; $display("FAIL t1_idle_motion got=%0d exp=0", bm); end
        checks++; if (solved_flag !== 1'b1) begin failures++; $display("FAIL t1_solved_flag got=%b exp=1", solved_flag); end
        checks++; if (step_count !== CW'(1)) begin failures++; $display("FAIL t1_step_count got=%0d exp=1", step_count); end
        checks++; if (zero_pos !== 4'd0) begin failures++; $display("FAIL t1_zero_pos got=%0d exp=0", zero_pos); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy got=%b exp=0", busy); end
    endtask

    task automatic test_multi_solve();
        int mv, fm, lm, da, bm;
        set_board(BOARD_Z3);
        push_move(M_RIGHT);
        push_move(M_RIGHT);
        // third move written in the same cycle as start
        wr_valid = 1'b1; wr_motion = M_RIGHT; start = 1'b1; init_zero_pos = 4'd3;
        tick();
        wr_valid = 1'b0; start = 1'b0;
        run_play(12, mv, fm, lm, da, bm);
        checks++; if (mv !== 3) begin failures++; $display("FAIL t2_moves got=%0d exp=3", mv); end
        checks++; if (fm !== 0 || lm !== 2) begin failures++; $display("FAIL t2_consecutive got=%0d..%0d exp=0..2", fm, lm); end
        checks++; if (da !== 4) begin failures++; $display("FAIL t2_done_cycle got=%0d exp=4", da); end
        checks++; if (solved_flag !== 1'b1) begin failures++; $display("FAIL t2_solved_flag got=%b exp=1", solved_flag); end
        checks++; if (step_count !== CW'(3)) begin failures++; $display("FAIL t2_step_count got=%0d exp=3", step_count); end
        checks++; if (zero_pos !== 4'd0) begin failures++; $display("FAIL t2_zero_pos got=%0d exp=0", zero_pos); end
    endtask

    task automatic test_illegal();
        int mv, fm, lm, da, bm;
        set_board(BOARD_Z1);
        push_move(M_RIGHT);
        pulse_start(4'd0);
        run_play(6, mv, fm, lm, da, bm);
        checks++; if (mv !== 0) begin failures++; $display("FAIL t3_moves got=%0d exp=0", mv); end
        checks++; if (da !== -1) begin failures++; $display("FAIL t3_done got_cycle=%0d exp=none", da); end
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL t3_illegal got=%b exp=1", illegal); end
        checks++; if (busy !== 1'b0 || wr_ready !== 1'b0) begin
            failures++; $display("FAIL t3_err_state got busy=%b wr_ready=%b exp 0 0", busy, wr_ready); end
        checks++; if (step_count !== '0) begin failures++; $display("FAIL t3_step_count got=%0d exp=0", step_count); end
        pulse_start(4'd1);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || illegal !== 1'b1 || zero_pos !== 4'd0) begin
            failures++; $display("FAIL t3_start_ignored got busy=%b illegal=%b zpos=%0d exp 0 1 0", busy, illegal, zero_pos); end
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        @(negedge clk);
        checks++; if (illegal !== 1'b0 || wr_ready !== 1'b1) begin
            failures++; $display("FAIL t3_clear got illegal=%b wr_ready=%b exp 0 1", illegal, wr_ready); end
        tick();
    endtask

    task automatic test_solve_flush();
        int mv, fm, lm, da, bm;
        set_board(BOARD_Z1);
        push_move(M_RIGHT);
        push_move(M_LEFT);
        push_move(M_LEFT);
        pulse_start(4'd1);
        run_play(10, mv, fm, lm, da, bm);
        checks++; if (mv !== 1) begin failures++; $display("FAIL t4_moves got=%0d exp=1", mv); end
        checks++; if (da !== 2) begin failures++; $display("FAIL t4_done_cycle got=%0d exp=2", da); end
        checks++; if (solved_flag !== 1'b1 || step_count !== CW'(1)) begin
            failures++; $display("FAIL t4_status got flag=%b step=%0d exp 1 1", solved_flag, step_count); end
        set_board(BOARD_Z1);
        pulse_start(4'd1);
        run_play(6, mv, fm, lm, da, bm);
        checks++; if (mv !== 0 || da !== 1) begin
            failures++; $display("FAIL t4_flushed got moves=%0d done_cycle=%0d exp 0 1", mv, da); end
        checks++; if (solved_flag !== 1'b0 || step_count !== '0) begin
            failures++; $display("FAIL t4_empty_status got flag=%b step=%0d exp 0 0", solved_flag, step_count); end
    endtask

    task automatic test_back_to_back();
        int mv, fm, lm, da, bm, acc;
        logic last_ready;
        set_board(BOARD_Z5);
        acc = 0; last_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_motion = (i % 2 == 1) ? M_RIGHT : M_LEFT;
            @(negedge clk);
            if (wr_ready) acc++;
            last_ready = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (acc !== DEPTH) begin failures++; $display("FAIL t5_accepts got=%0d exp=%0d", acc, DEPTH); end
        checks++; if (last_ready !== 1'b0) begin failures++; $display("FAIL t5_full_ready got=%b exp=0", last_ready); end
        pulse_start(4'd5);
        run_play(40, mv, fm, lm, da, bm);
        checks++; if (mv !== DEPTH || fm !== 0 || lm !== DEPTH - 1) begin
            failures++; $display("FAIL t5_moves got=%0d (%0d..%0d) exp=%0d (0..%0d)", mv, fm, lm, DEPTH, DEPTH - 1); end
        checks++; if (da !== DEPTH + 1) begin failures++; $display("FAIL t5_done_cycle got=%0d exp=%0d", da, DEPTH + 1); end
        checks++; if (solved_flag !== 1'b0 || step_count !== CW'(DEPTH)) begin
            failures++; $display("FAIL t5_status got flag=%b step=%0d exp 0 %0d", solved_flag, step_count, DEPTH); end
        checks++; if (zero_pos !== 4'd5) begin failures++; $display("FAIL t5_zero_pos got=%0d exp=5", zero_pos); end
    endtask

    task automatic test_rst_mid_play();
        int mv, fm, lm, da, bm, early;
        set_board(BOARD_Z5);
        push_move(M_LEFT);
        push_move(M_RIGHT);
        push_move(M_LEFT);
        push_move(M_RIGHT);
        push_move(M_LEFT);
        pulse_start(4'd5);
        early = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (motion_valid) early++;
            tick();
        end
        checks++; if (early !== 2) begin failures++; $display("FAIL t6_early_moves got=%0d exp=2", early); end
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        checks++; if ({motion_valid, busy, done, solved_flag, illegal} !== 5'b0 || step_count !== '0 || zero_pos !== 4'd0) begin
            failures++; $display("FAIL t6_after_rst got mv=%b busy=%b done=%b flag=%b ill=%b step=%0d zpos=%0d exp all 0",
                                 motion_valid, busy, done, solved_flag, illegal, step_count, zero_pos); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL t6_wr_ready got=%b exp=1", wr_ready); end
        tick();
        set_board(BOARD_Z5);
        pulse_start(4'd5);
        run_play(6, mv, fm, lm, da, bm);
        checks++; if (mv !== 0 || da !== 1) begin
            failures++; $display("FAIL t6_list_lost got moves=%0d done_cycle=%0d exp 0 1", mv, da); end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_motion = 2'b00; start = 1'b0; clear = 1'b0;
        init_zero_pos = 4'd0; load_req = 1'b1; load_val = BOARD_Z1;
        test_reset();
        test_single_solve();
        test_multi_solve();
        test_illegal();
        test_solve_flush();
        test_back_to_back();
        test_rst_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
